// File: rtl/winograd_tile_scheduler.sv
// winograd_tile_scheduler
// Sequencer for a Winograd F(2x2,3x3) PE. Walks an IMG_H x IMG_W feature map
// in overlapping TILE x TILE tiles at step STRIDE (raster order, rows outer),
// issues one tile request per tile, and carries each accepted tile's
// coordinates through a PE_LATENCY-deep pipe so the PE's 2x2 result is
// tagged with its output origin. Holds the PE in reset while idle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      begin a frame (sampled only while idle)
//   busy       frame in progress (issuing or draining)
//   done       one-cycle end-of-frame pulse
//   tile_req   tile request pending
//   tile_row   top-left input row of requested tile
//   tile_col   top-left input column of requested tile
//   tile_ack   fetch unit accepts the pending tile this cycle
//   pe_reset   synchronous reset to the PE (high while idle)
//   out_valid  PE output valid this cycle
//   out_row    output row of that 2x2 result
//   out_col    output column of that 2x2 result
module winograd_tile_scheduler #(
    parameter int IMG_H      = 8,
    parameter int IMG_W      = 8,
    parameter int TILE       = 4,
    parameter int STRIDE     = 2,
    parameter int PE_LATENCY = 8,
    parameter int COORD_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               tile_req,
    output logic [COORD_W-1:0] tile_row,
    output logic [COORD_W-1:0] tile_col,
    input  logic               tile_ack,
    output logic               pe_reset,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_row,
    output logic [COORD_W-1:0] out_col
);

    localparam int TX    = (IMG_W - TILE) / STRIDE + 1;
    localparam int TY    = (IMG_H - TILE) / STRIDE + 1;
    localparam int NT    = TX * TY;
    localparam int CNT_W = $clog2(NT + 1);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - TILE);
    localparam logic [COORD_W-1:0] STEP     = COORD_W'(STRIDE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [COORD_W-1:0] row, col;
    logic [CNT_W-1:0]   cnt;
    logic               ack;

    // Latency pipe: stage 0 takes the accepted tile, stage PE_LATENCY-1 drives out_*.
    logic [PE_LATENCY-1:0]              vld_pipe;
    logic [PE_LATENCY-1:0][COORD_W-1:0] row_pipe;
    logic [PE_LATENCY-1:0][COORD_W-1:0] col_pipe;

    // True when the pipe will hold nothing after this edge: only the head
    // stage may be occupied (it leaves this edge), and nothing enters in DRAIN.
    logic pipe_empty_next;

    assign ack             = tile_req & tile_ack;
    assign pipe_empty_next = ~|vld_pipe[PE_LATENCY-2:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ISSUE;
                        row   <= '0;
                        col   <= '0;
                        cnt   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (ack) begin
                        if (col < COL_LAST) begin
                            col <= col + STEP;
                        end else begin
                            col <= '0;
                            row <= row + STEP;
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty_next) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            row_pipe <= '0;
            col_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PE_LATENCY-2:0], ack};
            row_pipe <= {row_pipe[PE_LATENCY-2:0], tile_row};
            col_pipe <= {col_pipe[PE_LATENCY-2:0], tile_col};
        end
    end

    assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign tile_req  = (state == S_ISSUE);
    assign tile_row  = row;
    assign tile_col  = col;
    assign pe_reset  = (state == S_IDLE);
    assign out_valid = vld_pipe[PE_LATENCY-1];
    assign out_row   = row_pipe[PE_LATENCY-1];
    assign out_col   = col_pipe[PE_LATENCY-1];

endmodule
